// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory loader and the instruction decoder.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [7:0] NOP_WORD_DEFAULT = 8'h00;

    // Instruction layout {ALU_Op, Rd, Rs1} for the 8-bit word
    localparam int ALU_OP_LSB = 4;
    localparam int ALU_OP_W   = 4;
    localparam int RD_LSB     = 2;
    localparam int RD_W       = 2;
    localparam int RS1_LSB    = 0;
    localparam int RS1_W      = 2;

    // Index width for a memory of the given depth; never below one bit
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM; the read register only updates on re, so it holds the last fetch.
module prog_mem_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with post-reset clear, streamed run-time program load and latency-1 fetch.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_hold,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [ADDR_W:0]   load_count
);

    localparam int                RAM_AW   = addr_bits(DEPTH);
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(DEPTH - 1);

    state_t              state;
    state_t              state_next;
    logic [RAM_AW-1:0]   clr_ptr;
    logic [RAM_AW-1:0]   ptr;
    logic [RAM_AW-1:0]   base_idx;
    logic                in_range;
    logic                fetch_acc;
    logic                beat;
    logic                restart;
    logic                from_ram_p1;
    logic                ram_we;
    logic                ram_re;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    assign base_idx = RAM_AW'({1'b0, ld_base} % DEPTH_C);
    assign in_range = ({1'b0, fetch_addr} < DEPTH_C);
    assign restart  = ld_start && (state == RUN || state == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // The state alone owns the single RAM port, so fetch and write never collide
    always_comb begin
        state_next = state;
        mem_ready  = 1'b0;
        ld_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = clr_ptr;
        ram_wdata  = NOP_WORD;
        fetch_acc  = 1'b0;
        beat       = 1'b0;
        case (state)
            CLEAR: begin
                ram_we = 1'b1;
                if (clr_ptr == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_ready = 1'b1;
                ram_addr  = RAM_AW'(fetch_addr);
                if (ld_start) begin
                    state_next = LOAD;
                end else if (fetch_req && !fetch_hold) begin
                    fetch_acc = 1'b1;
                    ram_re    = in_range;
                end
            end
            LOAD: begin
                ld_ready  = !ld_start;
                ram_addr  = ptr;
                ram_wdata = ld_data;
                beat      = ld_valid && !ld_start;
                ram_we    = beat;
                if (beat && ld_last) begin
                    state_next = RUN;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr    <= '0;
            ptr        <= '0;
            load_count <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= (clr_ptr == LAST_IDX) ? '0 : clr_ptr + RAM_AW'(1);
            end
            if (restart) begin
                ptr        <= base_idx;
                load_count <= '0;
            end else if (beat) begin
                ptr <= (ptr == LAST_IDX) ? '0 : ptr + RAM_AW'(1);
                if (load_count != DEPTH_C) begin
                    load_count <= load_count + CNT_W'(1);
                end
            end
        end
    end

    // Fetch stage p1: qualifiers registered alongside the RAM read register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            addr_err    <= 1'b0;
            from_ram_p1 <= 1'b0;
        end else if (!(state == RUN && !ld_start && fetch_hold)) begin
            fetch_valid <= fetch_acc;
            addr_err    <= fetch_acc && !in_range;
            if (fetch_acc) begin
                from_ram_p1 <= in_range;
            end
        end
    end

    assign fetch_instr = from_ram_p1 ? ram_rdata : NOP_WORD;

    prog_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench: a 256-word instance and a 16-word instance driven through clear, load and fetch.
module tb_prog_mem_loader;

    logic       clk;
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;

    // Instance A: default parameters
    logic       reset, fetch_req, fetch_hold, ld_start, ld_valid, ld_last;
    logic [7:0] fetch_addr, ld_base, ld_data;
    logic       mem_ready, fetch_valid, addr_err, ld_ready;
    logic [7:0] fetch_instr;
    logic [8:0] load_count;

    // Instance B: DEPTH = 16
    logic       reset_b, fetch_req_b, fetch_hold_b, ld_start_b, ld_valid_b, ld_last_b;
    logic [7:0] fetch_addr_b, ld_base_b, ld_data_b;
    logic       mem_ready_b, fetch_valid_b, addr_err_b, ld_ready_b;
    logic [7:0] fetch_instr_b;
    logic [8:0] load_count_b;

    prog_mem_loader dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_hold(fetch_hold),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .addr_err(addr_err),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .load_count(load_count)
    );

    prog_mem_loader #(.DEPTH(16)) dut16 (
        .clk(clk), .reset(reset_b), .mem_ready(mem_ready_b),
        .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_hold(fetch_hold_b),
        .fetch_valid(fetch_valid_b), .fetch_instr(fetch_instr_b), .addr_err(addr_err_b),
        .ld_start(ld_start_b), .ld_base(ld_base_b), .ld_valid(ld_valid_b), .ld_ready(ld_ready_b),
        .ld_data(ld_data_b), .ld_last(ld_last_b), .load_count(load_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_chk(input bit b, input logic [7:0] a, input logic [7:0] exp_i,
                             input bit exp_e, input string tag);
        if (b) begin fetch_req_b = 1'b1; fetch_addr_b = a; end
        else   begin fetch_req   = 1'b1; fetch_addr   = a; end
        @(negedge clk);
        chk({tag, ".valid"}, b ? fetch_valid_b : fetch_valid, 1);
        chk({tag, ".instr"}, b ? fetch_instr_b : fetch_instr, exp_i);
        chk({tag, ".err"},   b ? addr_err_b    : addr_err,    exp_e);
    endtask

    task automatic beat(input bit b, input logic [7:0] d, input bit last);
        if (b) begin ld_valid_b = 1'b1; ld_data_b = d; ld_last_b = last; end
        else   begin ld_valid   = 1'b1; ld_data   = d; ld_last   = last; end
        @(negedge clk);
        if (b) begin ld_valid_b = 1'b0; ld_last_b = 1'b0; end
        else   begin ld_valid   = 1'b0; ld_last   = 1'b0; end
    endtask

    task automatic start_load(input bit b, input logic [7:0] base);
        if (b) begin ld_start_b = 1'b1; ld_base_b = base; end
        else   begin ld_start   = 1'b1; ld_base   = base; end
        @(negedge clk);
        if (b) ld_start_b = 1'b0;
        else   ld_start   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (mem_ready !== 1'b1 && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(tag, cnt, 256);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; fetch_req = 0; fetch_hold = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
        fetch_addr = '0; ld_base = '0; ld_data = '0;
        reset_b = 1'b1; fetch_req_b = 0; fetch_hold_b = 0; ld_start_b = 0; ld_valid_b = 0;
        ld_last_b = 0; fetch_addr_b = '0; ld_base_b = '0; ld_data_b = '0;

        repeat (2) @(negedge clk);
        chk("rst.mem_ready",   mem_ready,   0);
        chk("rst.ld_ready",    ld_ready,    0);
        chk("rst.fetch_valid", fetch_valid, 0);
        chk("rst.fetch_instr", fetch_instr, 8'h00);
        chk("rst.addr_err",    addr_err,    0);
        chk("rst.load_count",  load_count,  0);
        reset = 1'b0;
        reset_b = 1'b0;

        // 1: clear takes exactly DEPTH cycles, then a cleared word reads back as NOP
        wait_ready("t1.clear_cycles");
        chk("t1.b_ready", mem_ready_b, 1);
        fetch_chk(0, 8'h05, 8'h00, 0, "t1.fetch5");
        fetch_req = 1'b0;
        @(negedge clk);
        chk("t1.idle_valid", fetch_valid, 0);

        // 2: four-beat program, then back-to-back fetches
        ld_start = 1'b1; ld_base = 8'h00;
        #1 chk("t2.ready_on_start", ld_ready, 0);
        @(negedge clk);
        ld_start = 1'b0;
        #1 chk("t2.ld_ready", ld_ready, 1);
        chk("t2.mem_ready_low", mem_ready, 0);
        beat(0, 8'h01, 0);
        beat(0, 8'h1C, 0);
        beat(0, 8'h82, 0);
        beat(0, 8'h2C, 1);
        chk("t2.load_count", load_count, 4);
        chk("t2.mem_ready", mem_ready, 1);
        fetch_chk(0, 8'h00, 8'h01, 0, "t2.f0");
        fetch_chk(0, 8'h01, 8'h1C, 0, "t2.f1");
        fetch_chk(0, 8'h02, 8'h82, 0, "t2.f2");
        fetch_chk(0, 8'h03, 8'h2C, 0, "t2.f3");
        fetch_req = 1'b0;

        // 4: hold freezes the fetch outputs while the address moves
        fetch_chk(0, 8'h02, 8'h82, 0, "t4.fetch2");
        fetch_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 8'h00 + 8'(i);
            @(negedge clk);
            chk("t4.hold_valid", fetch_valid, 1);
            chk("t4.hold_instr", fetch_instr, 8'h82);
        end
        fetch_hold = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("t4.after_valid", fetch_valid, 0);
        chk("t4.after_instr", fetch_instr, 8'h82);

        // 5: ld_start beats fetch_req; restart mid-load
        fetch_req = 1'b1; fetch_addr = 8'h01; ld_start = 1'b1; ld_base = 8'h00;
        @(negedge clk);
        fetch_req = 1'b0; ld_start = 1'b0;
        #1 chk("t5.dropped_valid", fetch_valid, 0);
        chk("t5.ld_ready", ld_ready, 1);
        chk("t5.instr_kept", fetch_instr, 8'h82);
        beat(0, 8'hD0, 0);
        chk("t5.count1", load_count, 1);
        ld_last = 1'b1;
        @(negedge clk);
        ld_last = 1'b0;
        chk("t5.lone_last_state", mem_ready, 0);
        chk("t5.lone_last_count", load_count, 1);
        ld_start = 1'b1; ld_base = 8'h10; ld_valid = 1'b1; ld_data = 8'hEE;
        #1 chk("t5.restart_ready", ld_ready, 0);
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        chk("t5.restart_count", load_count, 0);
        beat(0, 8'h5A, 1);
        chk("t5.count_after", load_count, 1);
        chk("t5.run", mem_ready, 1);
        fetch_chk(0, 8'h10, 8'h5A, 0, "t5.f10");
        fetch_chk(0, 8'h00, 8'hD0, 0, "t5.f00");
        fetch_chk(0, 8'h01, 8'h1C, 0, "t5.f01");
        fetch_req = 1'b0;

        // 3: DEPTH=16 wrap, out-of-range fetch, base reduction, count saturation
        start_load(1, 8'd14);
        beat(1, 8'hA1, 0);
        beat(1, 8'hA2, 0);
        beat(1, 8'hA3, 0);
        beat(1, 8'hA4, 1);
        chk("t3.count", load_count_b, 4);
        fetch_chk(1, 8'd14, 8'hA1, 0, "t3.f14");
        fetch_chk(1, 8'd15, 8'hA2, 0, "t3.f15");
        fetch_chk(1, 8'd0,  8'hA3, 0, "t3.f0");
        fetch_chk(1, 8'd1,  8'hA4, 0, "t3.f1");
        fetch_chk(1, 8'd16, 8'h00, 1, "t3.f16");
        fetch_chk(1, 8'd5,  8'h00, 0, "t3.f5");
        fetch_req_b = 1'b0;
        start_load(1, 8'h13);
        beat(1, 8'hB7, 1);
        fetch_chk(1, 8'd3, 8'hB7, 0, "t3.base_mod");
        fetch_req_b = 1'b0;
        start_load(1, 8'h00);
        for (int i = 0; i < 17; i++) begin
            beat(1, 8'hC0 + 8'(i), (i == 16));
        end
        chk("t3.count_sat", load_count_b, 16);
        fetch_chk(1, 8'd0, 8'hD0, 0, "t3.wrap0");
        fetch_chk(1, 8'd1, 8'hC1, 0, "t3.wrap1");
        fetch_req_b = 1'b0;

        // 6: reset in the middle of a load
        start_load(0, 8'h20);
        beat(0, 8'h11, 0);
        beat(0, 8'h22, 0);
        reset = 1'b1;
        #1 chk("t6.mem_ready",   mem_ready,   0);
        chk("t6.ld_ready",    ld_ready,    0);
        chk("t6.fetch_valid", fetch_valid, 0);
        chk("t6.fetch_instr", fetch_instr, 8'h00);
        chk("t6.addr_err",    addr_err,    0);
        chk("t6.load_count",  load_count,  0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready("t6.clear_cycles");
        fetch_chk(0, 8'h20, 8'h00, 0, "t6.f20");
        fetch_chk(0, 8'h21, 8'h00, 0, "t6.f21");
        fetch_chk(0, 8'h02, 8'h00, 0, "t6.f02");
        fetch_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
